// File: rtl/pulse_checker.sv
// pulse_checker: receive-side monitor for the BIST pulse burst.
// Watches the controller's pulse, running and bist_end lines, checks that the
// burst is exactly N_PULSES pulses of N_HIGH cycles separated by N_LOW-cycle
// gaps and terminated by bist_end, then holds a pass/fail verdict with a code.
module pulse_checker #(
   parameter int N_HIGH   = 8,
   parameter int N_LOW    = 1,
   parameter int N_PULSES = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pulse_in,
   input  logic       running_in,
   input  logic       bist_end_in,
   output logic       done,
   output logic       pass,
   output logic       fail,
   output logic [2:0] err_code,
   output logic [3:0] pulse_count
);

   localparam logic [3:0] HIGH_LEN    = 4'(N_HIGH);
   localparam logic [3:0] LOW_LEN     = 4'(N_LOW);
   localparam logic [3:0] PULSE_TOTAL = 4'(N_PULSES);

   localparam logic [2:0] ERR_NONE       = 3'd0;
   localparam logic [2:0] ERR_HIGH_SHORT = 3'd1;
   localparam logic [2:0] ERR_HIGH_LONG  = 3'd2;
   localparam logic [2:0] ERR_GAP        = 3'd3;
   localparam logic [2:0] ERR_ABORT      = 3'd4;
   localparam logic [2:0] ERR_EXTRA      = 3'd5;
   localparam logic [2:0] ERR_EARLY_END  = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HIGH,
      ST_LOW,
      ST_DONE,
      ST_FAIL
   } state_t;

   state_t     state_reg, state_next;
   logic [3:0] high_cnt_reg, high_cnt_next;
   logic [3:0] low_cnt_reg, low_cnt_next;
   logic [3:0] pulse_cnt_reg, pulse_cnt_next;
   logic [2:0] err_reg, err_next;
   logic       prev_running_reg;
   // After reset the line must be seen low once before a start is accepted,
   // so the tail of an interrupted burst is not mistaken for a new one.
   logic       armed_reg, armed_next;

   logic       take_fail;
   logic [2:0] fail_code;
   logic [3:0] pulse_cnt_inc;
   logic       pulse_ok;
   logic       fresh_start;

   assign pulse_cnt_inc = pulse_cnt_reg + 4'd1;
   assign pulse_ok      = (high_cnt_reg == HIGH_LEN);
   assign fresh_start   = pulse_in & running_in & ~prev_running_reg;

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   // State and counter registers; prev_running tracks running_in every cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= ST_IDLE;
         high_cnt_reg     <= 4'd0;
         low_cnt_reg      <= 4'd0;
         pulse_cnt_reg    <= 4'd0;
         err_reg          <= ERR_NONE;
         prev_running_reg <= 1'b0;
         armed_reg        <= 1'b0;
      end else begin
         state_reg        <= state_next;
         high_cnt_reg     <= high_cnt_next;
         low_cnt_reg      <= low_cnt_next;
         pulse_cnt_reg    <= pulse_cnt_next;
         err_reg          <= err_next;
         prev_running_reg <= running_in;
         armed_reg        <= armed_next;
      end
   end

   // Next-state logic: burst shape checks with end/abort taking priority.
   always_comb begin
      state_next     = state_reg;
      high_cnt_next  = high_cnt_reg;
      low_cnt_next   = low_cnt_reg;
      pulse_cnt_next = pulse_cnt_reg;
      err_next       = err_reg;
      armed_next     = armed_reg;
      take_fail      = 1'b0;
      fail_code      = ERR_NONE;

      unique case (state_reg)
         ST_IDLE: begin
            if (!pulse_in) begin
               armed_next = 1'b1;
            end else if (running_in && armed_reg) begin
               state_next     = ST_HIGH;
               high_cnt_next  = 4'd1;
               pulse_cnt_next = 4'd0;
               err_next       = ERR_NONE;
            end
         end
         ST_HIGH: begin
            if (pulse_in) begin
               if (bist_end_in) begin
                  take_fail = 1'b1; fail_code = ERR_EARLY_END;
               end else if (!running_in) begin
                  take_fail = 1'b1; fail_code = ERR_ABORT;
               end else if (high_cnt_reg >= HIGH_LEN) begin
                  take_fail = 1'b1; fail_code = ERR_HIGH_LONG;
               end else begin
                  high_cnt_next = sat_inc(high_cnt_reg);
               end
            end else begin
               // A correctly sized pulse counts even if the same sample fails.
               if (pulse_ok) begin
                  pulse_cnt_next = pulse_cnt_inc;
               end
               if (pulse_ok && (pulse_cnt_inc == PULSE_TOTAL)) begin
                  if (!running_in && bist_end_in) begin
                     state_next = ST_DONE;
                     err_next   = ERR_NONE;
                  end else if (running_in) begin
                     take_fail = 1'b1; fail_code = ERR_EXTRA;
                  end else begin
                     take_fail = 1'b1; fail_code = ERR_ABORT;
                  end
               end else if (bist_end_in) begin
                  take_fail = 1'b1; fail_code = ERR_EARLY_END;
               end else if (!running_in) begin
                  take_fail = 1'b1; fail_code = ERR_ABORT;
               end else if (!pulse_ok) begin
                  take_fail = 1'b1; fail_code = ERR_HIGH_SHORT;
               end else begin
                  state_next   = ST_LOW;
                  low_cnt_next = 4'd1;
               end
            end
         end
         ST_LOW: begin
            if (bist_end_in) begin
               take_fail = 1'b1; fail_code = ERR_EARLY_END;
            end else if (!running_in) begin
               take_fail = 1'b1; fail_code = ERR_ABORT;
            end else if (pulse_in) begin
               if (low_cnt_reg != LOW_LEN) begin
                  take_fail = 1'b1; fail_code = ERR_GAP;
               end else begin
                  state_next    = ST_HIGH;
                  high_cnt_next = 4'd1;
               end
            end else if (low_cnt_reg >= LOW_LEN) begin
               take_fail = 1'b1; fail_code = ERR_GAP;
            end else begin
               low_cnt_next = sat_inc(low_cnt_reg);
            end
         end
         ST_DONE, ST_FAIL: begin
            // Only a burst that starts fresh re-arms; a still-running one never does.
            if (fresh_start) begin
               state_next     = ST_HIGH;
               high_cnt_next  = 4'd1;
               pulse_cnt_next = 4'd0;
               err_next       = ERR_NONE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      if (take_fail) begin
         state_next = ST_FAIL;
         err_next   = fail_code;
      end
   end

   // Verdict outputs decoded from registered state only.
   always_comb begin
      done        = (state_reg == ST_DONE) || (state_reg == ST_FAIL);
      pass        = (state_reg == ST_DONE);
      fail        = (state_reg == ST_FAIL);
      err_code    = err_reg;
      pulse_count = pulse_cnt_reg;
   end

endmodule

// File: tb/tb_pulse_checker.sv
// tb_pulse_checker: table-driven and randomized bench for pulse_checker,
// checked cycle by cycle against a run-length reference model.
module tb_pulse_checker;

   localparam int NH = 8;
   localparam int NL = 1;
   localparam int NP = 10;

   localparam logic [2:0] E_NONE  = 3'd0;
   localparam logic [2:0] E_SHORT = 3'd1;
   localparam logic [2:0] E_LONG  = 3'd2;
   localparam logic [2:0] E_GAP   = 3'd3;
   localparam logic [2:0] E_ABORT = 3'd4;
   localparam logic [2:0] E_EXTRA = 3'd5;
   localparam logic [2:0] E_EARLY = 3'd6;

   localparam int M_IDLE   = 0;
   localparam int M_ACTIVE = 1;
   localparam int M_HOLD   = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       pulse_in = 1'b0, running_in = 1'b0, bist_end_in = 1'b0;
   logic       done, pass, fail;
   logic [2:0] err_code;
   logic [3:0] pulse_count;
   logic [9:0] dut_out;

   logic       s_pulse = 1'b0, s_run = 1'b0, s_end = 1'b0;
   logic       s_done, s_pass, s_fail;
   logic [2:0] s_err;
   logic [3:0] s_cnt;
   logic [9:0] s_out;

   always #5 clk = ~clk;

   pulse_checker dut (
      .clk(clk), .reset(reset), .pulse_in(pulse_in), .running_in(running_in),
      .bist_end_in(bist_end_in), .done(done), .pass(pass), .fail(fail),
      .err_code(err_code), .pulse_count(pulse_count)
   );

   pulse_checker #(.N_HIGH(3), .N_LOW(2), .N_PULSES(4)) dut_small (
      .clk(clk), .reset(reset), .pulse_in(s_pulse), .running_in(s_run),
      .bist_end_in(s_end), .done(s_done), .pass(s_pass), .fail(s_fail),
      .err_code(s_err), .pulse_count(s_cnt)
   );

   assign dut_out = {done, pass, fail, err_code, pulse_count};
   assign s_out   = {s_done, s_pass, s_fail, s_err, s_cnt};

   int checks = 0;
   int errors = 0;

   function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endfunction

   // ---------------- reference model ----------------
   typedef struct packed {logic p; logic r; logic b;} smp_t;
   typedef struct {int status; logic [2:0] err; int cnt;} verdict_t;

   smp_t       hist[$];
   int         m_mode = M_IDLE;
   logic       m_armed = 1'b0;
   logic       m_prev_r = 1'b0;
   logic [9:0] m_out = 10'd0;

   // Judge a burst from its recorded samples by run lengths of high/low levels.
   // status 0 = still pending, 1 = pass, 2 = fail.
   function automatic verdict_t judge(input smp_t h[$]);
      verdict_t   v;
      int         run;
      int         lim;
      logic       hi;
      logic [2:0] e;
      smp_t       s;
      v.status = 0; v.err = E_NONE; v.cnt = 0;
      run = 1; hi = 1'b1;
      for (int i = 1; i < h.size(); i++) begin
         s = h[i];
         if (hi && !s.p && run == NH) begin
            v.cnt++;
            if (v.cnt == NP) begin
               if (!s.r && s.b) v.status = 1;
               else begin
                  v.status = 2;
                  v.err = s.r ? E_EXTRA : E_ABORT;
               end
               return v;
            end
         end
         lim = hi ? NH : NL;
         if (s.b) e = E_EARLY;
         else if (!s.r) e = E_ABORT;
         else if (s.p == hi) e = (run + 1 > lim) ? (hi ? E_LONG : E_GAP) : E_NONE;
         else e = (run != lim) ? (hi ? E_SHORT : E_GAP) : E_NONE;
         if (e != E_NONE) begin
            v.status = 2; v.err = e;
            return v;
         end
         if (s.p == hi) run++;
         else begin
            run = 1; hi = s.p;
         end
      end
      return v;
   endfunction

   task automatic model_start(input smp_t s);
      hist.delete();
      hist.push_back(s);
      m_mode = M_ACTIVE;
      m_out  = 10'd0;
   endtask

   task automatic model_step(input smp_t s, input logic rst);
      verdict_t v;
      if (rst) begin
         m_mode = M_IDLE; m_armed = 1'b0; m_prev_r = 1'b0; m_out = 10'd0;
         hist.delete();
         return;
      end
      case (m_mode)
         M_IDLE: begin
            if (!s.p) m_armed = 1'b1;
            else if (s.r && m_armed) model_start(s);
         end
         M_ACTIVE: begin
            hist.push_back(s);
            v = judge(hist);
            if (v.status == 1) m_out = {1'b1, 1'b1, 1'b0, E_NONE, 4'(v.cnt)};
            else if (v.status == 2) m_out = {1'b1, 1'b0, 1'b1, v.err, 4'(v.cnt)};
            else m_out = {6'd0, 4'(v.cnt)};
            if (v.status != 0) m_mode = M_HOLD;
         end
         default: begin
            if (s.p && s.r && !m_prev_r) model_start(s);
         end
      endcase
      m_prev_r = s.r;
   endtask

   // ---------------- stimulus ----------------
   int         burst_no = 0;
   int         bidx = 0;
   int         done_at = 0;
   logic [2:0] first_out = 3'd0;
   logic [9:0] rst_out = 10'd0;

   task automatic apply(input logic p, input logic r, input logic b, input logic rst);
      smp_t s;
      pulse_in = p; running_in = r; bist_end_in = b; reset = rst;
      @(posedge clk);
      s.p = p; s.r = r; s.b = b;
      model_step(s, rst);
      #1;
      bidx++;
      if (done === 1'b1 && done_at == 0) done_at = bidx;
      if (bidx == 1) first_out = {done, pass, fail};
      if (rst) rst_out = dut_out;
      check($sformatf("model burst %0d sample %0d", burst_no, bidx), 32'(dut_out), 32'(m_out));
   endtask

   task automatic run_burst(input int n_pulses, input int hl_pulse, input int hl_len,
                            input int gap_idx, input int gap_len, input int drop_idx,
                            input int end_idx, input bit keep_running, input int rst_at);
      bit dropped;
      int s;
      int len;
      dropped = 1'b0; s = 0; bidx = 0; done_at = 0;
      burst_no++;
      for (int k = 1; k <= n_pulses; k++) begin
         len = (k == hl_pulse) ? hl_len : NH;
         for (int c = 0; c < len; c++) begin
            if (k == drop_idx && c == 1) dropped = 1'b1;
            s++;
            apply(1'b1, !dropped, (k == end_idx && c == 1), s == rst_at);
         end
         if (k < n_pulses) begin
            len = (k == gap_idx) ? gap_len : NL;
            for (int c = 0; c < len; c++) begin
               s++;
               apply(1'b0, !dropped, 1'b0, s == rst_at);
            end
         end
      end
      s++;
      if (keep_running) apply(1'b0, 1'b1, 1'b0, s == rst_at);
      else apply(1'b0, 1'b0, 1'b1, s == rst_at);
   endtask

   typedef struct {
      string      name;
      int         n_pulses, hl_pulse, hl_len, gap_idx, gap_len, drop_idx, end_idx;
      bit         keep_running;
      logic       exp_pass;
      logic [2:0] exp_err;
      logic [3:0] exp_cnt;
   } vec_t;
   vec_t vecs[$];

   task automatic add_vec(input string name, input int n, input int hp, input int hl,
                          input int gi, input int gl, input int di, input int ei,
                          input bit kr, input logic ep, input logic [2:0] ee, input logic [3:0] ec);
      vec_t v;
      v.name = name; v.n_pulses = n; v.hl_pulse = hp; v.hl_len = hl; v.gap_idx = gi;
      v.gap_len = gl; v.drop_idx = di; v.end_idx = ei; v.keep_running = kr;
      v.exp_pass = ep; v.exp_err = ee; v.exp_cnt = ec;
      vecs.push_back(v);
   endtask

   int sidx = 0;
   int s_done_at = 0;

   task automatic apply_small(input logic p, input logic r, input logic b);
      s_pulse = p; s_run = r; s_end = b;
      @(posedge clk);
      #1;
      sidx++;
      if (s_done === 1'b1 && s_done_at == 0) s_done_at = sidx;
   endtask

   task automatic small_burst(input int gap_idx, input int gap_len);
      int len;
      sidx = 0; s_done_at = 0;
      for (int k = 1; k <= 4; k++) begin
         for (int c = 0; c < 3; c++) apply_small(1'b1, 1'b1, 1'b0);
         if (k < 4) begin
            len = (k == gap_idx) ? gap_len : 2;
            for (int c = 0; c < len; c++) apply_small(1'b0, 1'b1, 1'b0);
         end
      end
      apply_small(1'b0, 1'b0, 1'b1);
      apply_small(1'b0, 1'b0, 1'b0);
      apply_small(1'b0, 1'b0, 1'b0);
   endtask

   int r_np, r_hp, r_hl, r_gi, r_gl, r_di, r_ei, r_rst, r_idle;
   bit r_kr;

   initial begin
      // Reset state
      apply(1'b0, 1'b0, 1'b0, 1'b1);
      apply(1'b0, 1'b0, 1'b0, 1'b1);
      check("reset outputs", 32'(dut_out), 32'd0);
      check("reset outputs small", 32'(s_out), 32'd0);
      apply(1'b0, 1'b0, 1'b0, 1'b0);
      apply(1'b0, 1'b0, 1'b0, 1'b0);

      // Back-to-back good bursts: pass lands on the completion sample (90)
      run_burst(NP, 0, NH, 0, NL, 0, 0, 1'b0, 0);
      check("good latency", 32'(done_at), 32'd90);
      check("good verdict", 32'(dut_out), 32'({3'b110, E_NONE, 4'd10}));
      $display("burst %0d good: done at sample %0d, pass=%0d count=%0d", burst_no, done_at, pass, pulse_count);
      run_burst(NP, 0, NH, 0, NL, 0, 0, 1'b0, 0);
      check("restart clears verdict", 32'(first_out), 32'd0);
      check("second latency", 32'(done_at), 32'd90);
      check("second verdict", 32'(dut_out), 32'({3'b110, E_NONE, 4'd10}));
      $display("burst %0d back-to-back: done at sample %0d, pass=%0d", burst_no, done_at, pass);
      apply(1'b0, 1'b0, 1'b0, 1'b0);

      // Table of single-fault bursts
      add_vec("short pulse 3",     NP, 3, NH-1, 0, NL, 0, 0, 1'b0, 1'b0, E_SHORT, 4'd2);
      add_vec("long pulse 3",      NP, 3, NH+1, 0, NL, 0, 0, 1'b0, 1'b0, E_LONG,  4'd2);
      add_vec("gap 2 after 4",     NP, 0, NH,   4, 2,  0, 0, 1'b0, 1'b0, E_GAP,   4'd4);
      add_vec("drop in pulse 6",   NP, 0, NH,   0, NL, 6, 0, 1'b0, 1'b0, E_ABORT, 4'd5);
      add_vec("running after 10",  NP, 0, NH,   0, NL, 0, 0, 1'b1, 1'b0, E_EXTRA, 4'd10);
      add_vec("end+drop pulse 2",  NP, 0, NH,   0, NL, 2, 2, 1'b0, 1'b0, E_EARLY, 4'd1);
      add_vec("short last pulse",  NP, NP, NH-1, 0, NL, 0, 0, 1'b0, 1'b0, E_EARLY, 4'd9);
      add_vec("nine pulses",       NP-1, 0, NH, 0, NL, 0, 0, 1'b0, 1'b0, E_EARLY, 4'd9);
      add_vec("no gap after 5",    NP, 0, NH,   5, 0,  0, 0, 1'b0, 1'b0, E_LONG,  4'd4);
      add_vec("good again",        NP, 0, NH,   0, NL, 0, 0, 1'b0, 1'b1, E_NONE,  4'd10);
      foreach (vecs[i]) begin
         run_burst(vecs[i].n_pulses, vecs[i].hl_pulse, vecs[i].hl_len, vecs[i].gap_idx,
                   vecs[i].gap_len, vecs[i].drop_idx, vecs[i].end_idx, vecs[i].keep_running, 0);
         apply(1'b0, 1'b0, 1'b0, 1'b0);
         apply(1'b0, 1'b0, 1'b0, 1'b0);
         check(vecs[i].name, 32'(dut_out),
               32'({1'b1, vecs[i].exp_pass, ~vecs[i].exp_pass, vecs[i].exp_err, vecs[i].exp_cnt}));
         $display("burst %0d %s: pass=%0d fail=%0d err=%0d count=%0d",
                  burst_no, vecs[i].name, pass, fail, err_code, pulse_count);
      end

      // Reset during pulse 5: outputs clear, the rest of pulse 5 is ignored,
      // pulses 6..10 are then judged as a short burst ending early.
      run_burst(NP, 0, NH, 0, NL, 0, 0, 1'b0, 4*(NH+NL) + 3);
      check("mid-burst reset outputs", 32'(rst_out), 32'd0);
      apply(1'b0, 1'b0, 1'b0, 1'b0);
      check("tail after reset", 32'(dut_out), 32'({3'b101, E_EARLY, 4'd5}));
      $display("burst %0d reset in pulse 5: err=%0d count=%0d", burst_no, err_code, pulse_count);
      run_burst(NP, 0, NH, 0, NL, 0, 0, 1'b0, 0);
      check("good after reset", 32'(dut_out), 32'({3'b110, E_NONE, 4'd10}));
      $display("burst %0d good after reset: pass=%0d count=%0d", burst_no, pass, pulse_count);

      // Randomized bursts against the model
      for (int n = 0; n < 40; n++) begin
         r_np = NP;
         if ($urandom_range(0, 5) == 0) r_np = NP - 1 + 2 * int'($urandom_range(0, 1));
         r_hp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, r_np)) : 0;
         r_hl = NH - 1 + int'($urandom_range(0, 2));
         r_gi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, r_np - 1)) : 0;
         r_gl = int'($urandom_range(0, 3));
         r_di = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, r_np)) : 0;
         r_ei = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, r_np)) : 0;
         r_kr = ($urandom_range(0, 7) == 0);
         r_rst = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 80)) : 0;
         if ($urandom_range(0, 7) == 0) apply(1'b0, 1'b0, 1'b0, 1'b1);
         run_burst(r_np, r_hp, r_hl, r_gi, r_gl, r_di, r_ei, r_kr, r_rst);
         r_idle = int'($urandom_range(0, 3));
         for (int i = 0; i < r_idle; i++) apply(1'b0, 1'b0, 1'b0, 1'b0);
         $display("burst %0d random: done=%0d pass=%0d err=%0d count=%0d",
                  burst_no, done, pass, err_code, pulse_count);
      end

      // Parameter override instance: 4 pulses of 3 high, 2-cycle gaps
      apply(1'b0, 1'b0, 1'b0, 1'b0);
      small_burst(0, 2);
      check("small latency", 32'(s_done_at), 32'd19);
      check("small good verdict", 32'(s_out), 32'({3'b110, E_NONE, 4'd4}));
      $display("small burst good: done at sample %0d, pass=%0d count=%0d", s_done_at, s_pass, s_cnt);
      small_burst(2, 1);
      check("small gap verdict", 32'(s_out), 32'({3'b101, E_GAP, 4'd2}));
      $display("small burst gap 1: fail=%0d err=%0d count=%0d", s_fail, s_err, s_cnt);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
